// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared state encoding and divide-ratio clamp for clock_divider
package clock_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam int unsigned MIN_DIV = 2;

    // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
    function automatic int unsigned clamp_div(input int unsigned value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

endpackage

// File: rtl/clock_div_shadow.sv
// rtl/clock_div_shadow.sv - pending/active divide-ratio pair with apply acknowledge
import clock_div_pkg::*;

module clock_div_shadow #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    input  logic             boundary,
    input  logic             idle,
    output logic [CNT_W-1:0] div_active,
    output logic             div_ack
);

    logic [CNT_W-1:0] pend_value;
    logic             pend_valid;
    logic [CNT_W-1:0] load_value;

    assign load_value = CNT_W'(clamp_div(32'(div_value)));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_active <= CNT_W'(DEFAULT_DIV);
            pend_value <= CNT_W'(DEFAULT_DIV);
            pend_valid <= 1'b0;
            div_ack    <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            if (boundary && div_load) begin
                // A load landing on the boundary skips the pending stage.
                div_active <= load_value;
                pend_valid <= 1'b0;
                div_ack    <= 1'b1;
            end else if ((boundary || idle) && pend_valid) begin
                div_active <= pend_value;
                div_ack    <= 1'b1;
                pend_valid <= div_load;
                if (div_load) begin
                    pend_value <= load_value;
                end
            end else if (div_load) begin
                pend_value <= load_value;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - programmable glitch-free clock divider with tick and reload handshake
import clock_div_pkg::*;

module clock_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    logic [1:0]       state;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W:0]   hi_len;
    logic [CNT_W-1:0] hi_last;
    logic [CNT_W-1:0] div_last;
    logic             boundary;
    logic             idle;

    // Widened by one bit so N = 2**CNT_W-1 does not overflow the rounding add.
    assign hi_len   = ({1'b0, div_active} + (CNT_W+1)'(1)) >> 1;
    assign hi_last  = CNT_W'(hi_len - (CNT_W+1)'(1));
    assign div_last = div_active - CNT_W'(1);
    assign boundary = (state == ST_LOW) && (count == div_last);
    assign idle     = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    clock_div_shadow #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clock      (clock),
        .reset_n    (reset_n),
        .div_load   (div_load),
        .div_value  (div_value),
        .boundary   (boundary),
        .idle       (idle),
        .div_active (div_active),
        .div_ack    (div_ack)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count   <= '0;
                    clk_out <= enable;
                    tick    <= enable;
                    if (enable) begin
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    count <= count + CNT_W'(1);
                    if (count == hi_last) begin
                        state   <= ST_LOW;
                        clk_out <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (boundary) begin
                        count   <= '0;
                        clk_out <= enable;
                        tick    <= enable;
                        state   <= enable ? ST_HIGH : ST_IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    count   <= '0;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - directed self-checking bench for clock_divider
module tb_clock_divider;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       div_load;
    logic [7:0] div_value;
    logic       div_ack;
    logic       clk_out;
    logic       tick;
    logic [7:0] count;
    logic       busy;
    logic [31:0] obs;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    clock_divider #(
        .CNT_W       (8),
        .DEFAULT_DIV (10)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .div_load  (div_load),
        .div_value (div_value),
        .div_ack   (div_ack),
        .clk_out   (clk_out),
        .tick      (tick),
        .count     (count),
        .busy      (busy)
    );

    // {ack, clk_out, tick, busy, count}
    assign obs = {20'd0, div_ack, clk_out, tick, busy, count};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected running outputs at phase p of a period of ratio n.
    function automatic logic [31:0] pat(input int n, input int p, input logic ack);
        logic hi;
        hi = (p < (n + 1) / 2);
        return {20'd0, ack, hi, (p == 0), 1'b1, 8'(p)};
    endfunction

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        div_load  = 1'b0;
        div_value = 8'd0;
        step();
        step();
        chk("reset", obs, 32'h0);
        reset_n = 1'b1;
        step();
        chk("idle_hold", obs, 32'h0);

        // default N=10, then reload 4 at count 3
        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk("n10_run", obs, pat(10, i % 10, 1'b0));
        end
        div_load  = 1'b1;
        div_value = 8'd4;
        for (int i = 24; i < 30; i++) begin
            step();
            div_load = 1'b0;
            chk("n10_keep_period", obs, pat(10, i % 10, 1'b0));
        end
        for (int j = 0; j < 8; j++) begin
            step();
            chk("n4_run", obs, pat(4, j % 4, j == 0));
        end

        // load 0 on a boundary, then load 1 mid-period: both run as 2
        div_load  = 1'b1;
        div_value = 8'd0;
        step();
        chk("clamp0_bypass", obs, pat(2, 0, 1'b1));
        div_value = 8'd1;
        step();
        div_load = 1'b0;
        chk("clamp1_pending", obs, pat(2, 1, 1'b0));
        step();
        chk("clamp1_apply", obs, pat(2, 0, 1'b1));
        for (int j = 1; j < 6; j++) begin
            step();
            chk("n2_run", obs, pat(2, j % 2, 1'b0));
        end

        // back to N=10, drop enable at count 2
        div_load  = 1'b1;
        div_value = 8'd10;
        step();
        div_load = 1'b0;
        chk("n10_bypass", obs, pat(10, 0, 1'b1));
        for (int i = 1; i < 3; i++) begin
            step();
            chk("n10_pre_stop", obs, pat(10, i, 1'b0));
        end
        enable = 1'b0;
        for (int i = 3; i < 10; i++) begin
            step();
            chk("n10_finish", obs, pat(10, i, 1'b0));
        end
        step();
        chk("stop_idle", obs, 32'h0);
        step();
        chk("idle_no_tick", obs, 32'h0);

        // load 3 in IDLE, ack one edge later, then run 2 high / 1 low
        div_load  = 1'b1;
        div_value = 8'd3;
        step();
        div_load = 1'b0;
        chk("idle_load_noack", obs, 32'h0);
        step();
        chk("idle_apply_ack", obs, 32'h800);
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("n3_run", obs, pat(3, i % 3, 1'b0));
        end

        // N=10 again, reset at count 7 with a load pending
        div_load  = 1'b1;
        div_value = 8'd10;
        step();
        div_load = 1'b0;
        chk("n10_reload", obs, pat(10, 0, 1'b1));
        for (int i = 1; i < 7; i++) begin
            step();
            chk("n10_pre_reset", obs, pat(10, i, 1'b0));
        end
        div_load  = 1'b1;
        div_value = 8'd3;
        step();
        div_load = 1'b0;
        chk("pending_at_7", obs, pat(10, 7, 1'b0));
        reset_n = 1'b0;
        step();
        chk("reset_mid_period", obs, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("after_reset_n10", obs, pat(10, i % 10, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
